// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU sequencer: micro-step codes, opcode
// encodings and the opcode legality check.
package cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    STATE_FETCH_PC   = 4'h0,
    STATE_FETCH_INST = 4'h1,
    STATE_LOAD_ADDR  = 4'h2,
    STATE_RAM_A      = 4'h3,
    STATE_RAM_B      = 4'h4,
    STATE_STORE_A    = 4'h5,
    STATE_ADD        = 4'h6,
    STATE_SUB        = 4'h7,
    STATE_OUT_A      = 4'h8,
    STATE_JUMP       = 4'h9,
    STATE_NEXT       = 4'hA,
    STATE_HALT       = 4'hB
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_OUT = 4'h5,
    OP_JMP = 4'h6,
    OP_JEZ = 4'h7,
    OP_JNZ = 4'h8,
    OP_JC  = 4'h9,
    OP_JNC = 4'hA,
    OP_HLT = 4'hB
  } op_e;

  // Encodings 4'hC..4'hF are reserved and trap.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT,
                      OP_JMP, OP_JEZ, OP_JNZ, OP_JC, OP_JNC, OP_HLT};
  endfunction

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational next-step logic: picks the following micro-step from the
// current step, cycle index, opcode and flags.
module cpu_seq_decode
  import cpu_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 4,
  parameter int CYCLE_W  = 3
) (
  input  logic [STATE_W-1:0]  state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [CYCLE_W-1:0]  cycle,
  input  logic                eq_zero,
  input  logic                carry,
  input  logic                halted,
  input  logic                illegal,
  input  logic                resume,
  output logic [STATE_W-1:0]  next_state,
  output logic                trap
);

  logic [3:0]  cur;
  logic [3:0]  op;
  logic        legal;
  int unsigned cyc;
  state_e      nxt;

  // NOTE: every output of this block gets a default before any branch, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    nxt   = STATE_NEXT;
    trap  = 1'b0;
    cur   = 4'(state);
    op    = 4'(opcode);
    cyc   = 32'(cycle);
    legal = is_legal_op(op) && (OPCODE_W'(op) == opcode);

    if (halted) begin
      // A trap can only be left through reset.
      nxt = (resume && !illegal) ? STATE_NEXT : STATE_HALT;
    end else if (cur == STATE_NEXT) begin
      nxt = STATE_FETCH_PC;
    end else begin
      case (cyc)
        0: nxt = STATE_FETCH_INST;
        1: begin
          if (!legal) begin
            nxt  = STATE_HALT;
            trap = 1'b1;
          end else begin
            case (op)
              OP_NOP:  nxt = STATE_NEXT;
              OP_OUT:  nxt = STATE_OUT_A;
              OP_HLT:  nxt = STATE_HALT;
              default: nxt = STATE_FETCH_PC;
            endcase
          end
        end
        2: begin
          case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: nxt = STATE_LOAD_ADDR;
            OP_JMP:  nxt = STATE_JUMP;
            OP_JEZ:  nxt = eq_zero  ? STATE_JUMP : STATE_NEXT;
            OP_JNZ:  nxt = !eq_zero ? STATE_JUMP : STATE_NEXT;
            OP_JC:   nxt = carry    ? STATE_JUMP : STATE_NEXT;
            OP_JNC:  nxt = !carry   ? STATE_JUMP : STATE_NEXT;
            default: nxt = STATE_NEXT;
          endcase
        end
        3: begin
          case (op)
            OP_LDA:         nxt = STATE_RAM_A;
            OP_STA:         nxt = STATE_STORE_A;
            OP_ADD, OP_SUB: nxt = STATE_RAM_B;
            default:        nxt = STATE_NEXT;
          endcase
        end
        4: begin
          case (op)
            OP_ADD:  nxt = STATE_ADD;
            OP_SUB:  nxt = STATE_SUB;
            default: nxt = STATE_NEXT;
          endcase
        end
        default: nxt = STATE_NEXT;
      endcase
    end
  end

  assign next_state = STATE_W'(nxt);

endmodule

// File: rtl/cpu_sequencer.sv
// CPU micro-sequencer: registers the current micro-step and cycle index,
// applies stall gating and keeps the halt and illegal-opcode status bits.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 4,
  parameter int CYCLE_W  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                eq_zero,
  input  logic                carry,
  input  logic                stall,
  input  logic                resume,
  output logic [STATE_W-1:0]  state,
  output logic [CYCLE_W-1:0]  cycle,
  output logic                halted,
  output logic                illegal,
  output logic                instr_done
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               done_q, done_d;
  logic [STATE_W-1:0] next_state;
  logic               trap;

  cpu_seq_decode #(
    .OPCODE_W(OPCODE_W),
    .STATE_W (STATE_W),
    .CYCLE_W (CYCLE_W)
  ) u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .cycle     (cycle_q),
    .eq_zero   (eq_zero),
    .carry     (carry),
    .halted    (halted_q),
    .illegal   (illegal_q),
    .resume    (resume),
    .next_state(next_state),
    .trap      (trap)
  );

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    done_d    = done_q;
    if (!stall) begin
      state_d = next_state;
      if (state_q == STATE_W'(STATE_NEXT)) begin
        cycle_d = '0;
      end else if (halted_q && next_state == STATE_W'(STATE_HALT)) begin
        cycle_d = cycle_q;
      end else begin
        cycle_d = cycle_q + CYCLE_W'(1);
      end
      halted_d  = (next_state == STATE_W'(STATE_HALT));
      illegal_d = illegal_q | trap;
      done_d    = (next_state == STATE_W'(STATE_NEXT));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STATE_W'(STATE_FETCH_PC);
      cycle_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign state      = state_q;
  assign cycle      = cycle_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign instr_done = done_q;

  // The longest sequence (ADD/SUB) ends at cycle 6.
  a_cycle_bound : assert property (@(posedge clk) disable iff (!reset_n)
    cycle_q != CYCLE_W'(7));

endmodule
